// File: rtl/wb_io_master_if.sv
// Wishbone classic bus between the I/O master and the demo_io peripheral subsystem.
// Signal names are from the master's point of view.
interface wb_io_master_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned ADR_W = 15;

   logic [ADR_W-1:0] adr_o;
   logic [WIDTH-1:0] dat_o;
   logic [WIDTH-1:0] dat_i;
   logic             we_o;
   logic             stb_o;
   logic             ack_i;

   modport master (output adr_o, dat_o, we_o, stb_o, input dat_i, ack_i);
   modport slave  (input adr_o, dat_o, we_o, stb_o, output dat_i, ack_i);
endinterface

// File: rtl/wb_io_master.sv
// Converts single-cycle CPU I/O requests into Wishbone transactions.
// Holds the strobe until ack, and has a bounded timeout so a missing ack cannot hang the CPU.
module wb_io_master #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             io_req,
   input  logic             io_we,
   input  logic [14:0]      io_adr,
   input  logic [WIDTH-1:0] io_wdat,
   input  logic             io_err_clr,
   output logic [WIDTH-1:0] io_rdat,
   output logic             io_busy,
   output logic             io_err,
   wb_io_master_if.master   wb
);
   localparam int unsigned ADR_W = 15;
   // Width 1 when the timeout is disabled, so the counter is never zero-width.
   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic {IDLE, STROBE} state_t;

   state_t           state_q, state_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] rdat_q, rdat_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         rdat_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         rdat_q  <= rdat_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; a timeout set overrides a clear on the same edge
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (io_err_clr) err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (io_req) begin
               adr_d   = io_adr;
               we_d    = io_we;
               dat_d   = io_wdat;
               cnt_d   = '0;
               state_d = STROBE;
            end
         end
         STROBE: begin
            if (wb.ack_i) begin
               if (!we_q) rdat_d = wb.dat_i;
               state_d = IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               if (!we_q) rdat_d = '1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign io_busy  = (state_q == STROBE);
   assign io_rdat  = rdat_q;
   assign io_err   = err_q;
   assign wb.stb_o = (state_q == STROBE);
   assign wb.adr_o = adr_q;
   assign wb.dat_o = dat_q;
   assign wb.we_o  = we_q;
endmodule
